// File: rtl/kbd_display_sequencer_pkg.sv
// Shared constants, FSM/op encodings and the scancode-to-segment lookup
// for the keyboard-to-7-segment sequencer.
package kbd_display_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK,
    ST_UPDATE
  } kbd_state_e;

  typedef enum logic {
    OP_PUSH,
    OP_POP
  } kbd_op_e;

  // Returns {hit, seg}; segments are active-low, bit7 = dp, bit0 = a.
  function automatic logic [8:0] scancode_to_seg(input logic [7:0] code);
    logic [8:0] r;
    r = {1'b0, SEG_BLANK};
    case (code)
      8'h45: r = {1'b1, 8'hC0};
      8'h16: r = {1'b1, 8'hF9};
      8'h1E: r = {1'b1, 8'hA4};
      8'h26: r = {1'b1, 8'hB0};
      8'h25: r = {1'b1, 8'h99};
      8'h2E: r = {1'b1, 8'h92};
      8'h36: r = {1'b1, 8'h82};
      8'h3D: r = {1'b1, 8'hF8};
      8'h3E: r = {1'b1, 8'h80};
      8'h46: r = {1'b1, 8'h90};
      8'h1C: r = {1'b1, 8'h88}; // A
      8'h32: r = {1'b1, 8'h83}; // b
      8'h21: r = {1'b1, 8'hC6}; // C
      8'h23: r = {1'b1, 8'hA1}; // d
      8'h24: r = {1'b1, 8'h86}; // E
      8'h2B: r = {1'b1, 8'h8E}; // F
      8'h33: r = {1'b1, 8'h89}; // H
      8'h43: r = {1'b1, 8'hF9}; // I
      8'h4B: r = {1'b1, 8'hC7}; // L
      8'h31: r = {1'b1, 8'hAB}; // n
      8'h44: r = {1'b1, 8'hC0}; // O
      8'h4D: r = {1'b1, 8'h8C}; // P
      8'h15: r = {1'b1, 8'h98}; // q
      8'h2D: r = {1'b1, 8'hAF}; // r
      8'h1B: r = {1'b1, 8'h92}; // S
      8'h2C: r = {1'b1, 8'h87}; // t
      8'h3C: r = {1'b1, 8'hC1}; // U
      8'h29: r = {1'b1, 8'hFF}; // space
      8'h4E: r = {1'b1, 8'hBF}; // -
      8'h49: r = {1'b1, 8'h7F}; // .
      default: r = {1'b0, SEG_BLANK};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbd_display_sequencer_if.sv
// Scancode byte handshake between the PS/2 receiver (master) and the sequencer (slave).
interface kbd_display_sequencer_if;
  logic [7:0] i_code;
  logic       i_code_valid;
  logic       o_code_ready;

  modport master (output i_code, output i_code_valid, input  o_code_ready);
  modport slave  (input  i_code, input  i_code_valid, output o_code_ready);
endinterface

// File: rtl/kbd_display_sequencer_seg_scan_mux.sv
// Time-multiplexes a 4-digit segment buffer onto shared anode/segment pins.
module seg_scan_mux #(
  parameter int SCAN_DIV = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [3:0][7:0] i_buf,
  output logic [3:0]      o_digit_sel,
  output logic [7:0]      o_seg
);

  logic [SCAN_DIV-1:0] pre_q;
  logic [1:0]          idx_q;

  // sel and seg are both registered from idx_q, so they always move together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q       <= '0;
      idx_q       <= 2'd0;
      o_digit_sel <= 4'b1110;
      o_seg       <= 8'hFF;
    end else begin
      pre_q       <= pre_q + SCAN_DIV'(1);
      if (&pre_q) idx_q <= idx_q + 2'd1;
      o_digit_sel <= ~(4'b0001 << idx_q);
      o_seg       <= i_buf[idx_q];
    end
  end

endmodule

// File: rtl/kbd_display_sequencer.sv
// PS/2 scancode parser feeding a 4-character display buffer with a
// backspace history stack; the scan mux drives the shared display pins.
module kbd_display_sequencer
  import kbd_display_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int HIST_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  kbd_display_sequencer_if.slave code_if,
  output logic [3:0]             o_digit_sel,
  output logic [7:0]             o_seg
);

  localparam int PW = $clog2(HIST_DEPTH + 1);

  kbd_state_e                  state_q, state_d;
  kbd_op_e                     op_q, op_d;
  logic [7:0]                  held_q, held_d;
  logic                        held_vld_q, held_vld_d;
  logic [7:0]                  pseg_q, pseg_d;
  logic [3:0][7:0]             buf_q, buf_d;
  logic [HIST_DEPTH-1:0][7:0]  hist_q, hist_d;
  logic [PW-1:0]               hcnt_q, hcnt_d;
  logic                        acc;
  logic [8:0]                  map;

  assign code_if.o_code_ready = (state_q != ST_UPDATE);
  assign acc = code_if.i_code_valid & code_if.o_code_ready;
  assign map = scancode_to_seg(code_if.i_code);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PUSH;
      held_q     <= 8'h00;
      held_vld_q <= 1'b0;
      pseg_q     <= SEG_BLANK;
      buf_q      <= {4{SEG_BLANK}};
      hist_q     <= {HIST_DEPTH{SEG_BLANK}};
      hcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      pseg_q     <= pseg_d;
      buf_q      <= buf_d;
      hist_q     <= hist_d;
      hcnt_q     <= hcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    pseg_d     = pseg_q;
    buf_d      = buf_q;
    hist_d     = hist_q;
    hcnt_d     = hcnt_q;
    case (state_q)
      ST_IDLE: if (acc) begin
        if (code_if.i_code == SC_BREAK)      state_d = ST_BREAK;
        else if (code_if.i_code == SC_EXT)   state_d = ST_EXT;
        else if (held_vld_q && code_if.i_code == held_q) state_d = ST_IDLE;
        else begin
          held_d     = code_if.i_code;
          held_vld_d = 1'b1;
          if (code_if.i_code == SC_BKSP) begin
            op_d    = OP_POP;
            state_d = ST_UPDATE;
          end else if (map[8]) begin
            op_d    = OP_PUSH;
            pseg_d  = map[7:0];
            state_d = ST_UPDATE;
          end
        end
      end
      ST_BREAK: if (acc) begin
        state_d = ST_IDLE;
        if (held_vld_q && code_if.i_code == held_q) held_vld_d = 1'b0;
      end
      ST_EXT: if (acc) begin
        state_d = (code_if.i_code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
      end
      ST_EXT_BREAK: if (acc) state_d = ST_IDLE;
      ST_UPDATE: begin
        state_d = ST_IDLE;
        if (op_q == OP_PUSH) begin
          // Stack top lives at index 0; shifting down drops the oldest when full.
          hist_d[0] = buf_q[3];
          for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
          if (hcnt_q != PW'(HIST_DEPTH)) hcnt_d = hcnt_q + PW'(1);
          buf_d = {buf_q[2:0], pseg_q};
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = buf_q[2];
          buf_d[2] = buf_q[3];
          buf_d[3] = (hcnt_q != '0) ? hist_q[0] : SEG_BLANK;
          for (int i = 0; i < HIST_DEPTH - 1; i++) hist_d[i] = hist_q[i+1];
          hist_d[HIST_DEPTH-1] = SEG_BLANK;
          if (hcnt_q != '0) hcnt_d = hcnt_q - PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seg_scan_mux #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_buf       (buf_q),
    .o_digit_sel (o_digit_sel),
    .o_seg       (o_seg)
  );

endmodule
